// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter: FSM state encoding,
// requester indices and the default requester count.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 3;

    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;
    localparam int unsigned REQ_ISB    = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

    // Width of a requester index; never zero so a single requester still gets a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection: the first valid requester at or after ptr_i,
// wrapping modulo NUM_REQ, reported as a one-hot grant and as an index.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int rank;
    int best;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        rank  = 0;
        best  = int'(NUM_REQ);
        // rank is the distance from the pointer; the smallest valid rank wins
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rank = (i + int'(NUM_REQ) - int'(ptr_i)) % int'(NUM_REQ);
            if (valid_i[i] && (rank < best)) begin
                best  = rank;
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates NUM_REQ read requesters onto one AXI AR/R master, one burst at a time.
// Define MEM_READ_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_rvalid,
    output logic                          req_rlast,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_WIDTH-1:0]          m_arlen,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          protocol_err
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH:0]      cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [IDX_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

    logic [ADDR_WIDTH-1:0]   araddr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]    arlen_arr  [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign araddr_arr[r] = req_araddr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_arr[r]  = req_arlen[r*LEN_WIDTH +: LEN_WIDTH];
    end

    mem_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i (req_arvalid),
        .ptr_i   (ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef MEM_READ_ARB_RR_EN
    logic             ptr_q, ptr_unused;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             burst_done;

    assign ptr_q      = 1'b0;
    assign ptr_unused = ptr_q;
    assign burst_done = (state_q == StData) && m_rvalid && req_rready[gidx_q] && m_rlast;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (burst_done) begin
            rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign ptr = rr_ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_arready  = '0;
        req_rvalid   = '0;
        req_rdata    = '0;
        req_rlast    = 1'b0;
        m_araddr     = '0;
        m_arlen      = '0;
        m_arid       = '0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // rst gates the accept pulse so no output is seen high during reset
                if (pick_any && !rst) begin
                    req_arready = pick_gnt;
                    gidx_d      = pick_idx;
                    addr_d      = araddr_arr[pick_idx];
                    len_d       = arlen_arr[pick_idx];
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                m_arvalid = 1'b1;
                m_araddr  = addr_q;
                m_arlen   = len_q;
                m_arid    = ID_WIDTH'(gidx_q);
                if (m_arready) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                req_rvalid[gidx_q] = m_rvalid;
                req_rdata          = m_rdata;
                req_rlast          = m_rlast;
                m_rready           = req_rready[gidx_q];
                if (m_rvalid && req_rready[gidx_q]) begin
                    cnt_d = cnt_q + 1'b1;
                    // rlast must coincide exactly with beat index arlen
                    if (m_rlast != (cnt_q == {1'b0, len_q})) begin
                        err_d = 1'b1;
                    end
                    if (m_rid != ID_WIDTH'(gidx_q)) begin
                        err_d = 1'b1;
                    end
                    if (m_rlast) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gidx_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign protocol_err = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a transaction-level reference model
// checked on every falling edge, plus literal checks on grant order and errors.
module tb_mem_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] req_araddr = '0;
    logic [N*LW-1:0] req_arlen = '0;
    logic [N-1:0]    req_arvalid = '0;
    logic [N-1:0]    req_arready;
    logic [DW-1:0]   req_rdata;
    logic [N-1:0]    req_rvalid;
    logic            req_rlast;
    logic [N-1:0]    req_rready = '1;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [IW-1:0]   m_arid;
    logic            m_arvalid;
    logic            m_arready = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic [IW-1:0]   m_rid = '0;
    logic            m_rlast = 1'b0;
    logic            m_rvalid = 1'b0;
    logic            m_rready;
    logic            protocol_err;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_araddr   (req_araddr),
        .req_arlen    (req_arlen),
        .req_arvalid  (req_arvalid),
        .req_arready  (req_arready),
        .req_rdata    (req_rdata),
        .req_rvalid   (req_rvalid),
        .req_rlast    (req_rlast),
        .req_rready   (req_rready),
        .m_araddr     (m_araddr),
        .m_arlen      (m_arlen),
        .m_arid       (m_arid),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_rdata      (m_rdata),
        .m_rid        (m_rid),
        .m_rlast      (m_rlast),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready),
        .protocol_err (protocol_err)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: who owns the bus, whether its address is still pending,
    // beats seen so far, sticky error and the round-robin start point.
    int             mo_owner = -1;
    bit             mo_addr_ph = 1'b0;
    logic [AW-1:0]  mo_addr = '0;
    int             mo_len = 0;
    int             mo_beats = 0;
    bit             mo_err = 1'b0;
    int             mo_ptr = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        logic [N-1:0]  e_arready, e_rvalid;
        logic          e_arvalid, e_rlast, e_rready;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_len;
        logic [IW-1:0] e_id;
        logic [DW-1:0] e_rdata;
        int            w;
        e_arready = '0; e_rvalid = '0; e_arvalid = 0; e_rlast = 0; e_rready = 0;
        e_addr = '0; e_len = '0; e_id = '0; e_rdata = '0; w = -1;
        if (rst) begin
            mo_owner = -1; mo_addr_ph = 0; mo_beats = 0; mo_err = 0; mo_ptr = 0;
        end else if (mo_owner < 0) begin
`ifdef MEM_READ_ARB_RR_EN
            w = pick(req_arvalid, mo_ptr);
`else
            w = pick(req_arvalid, 0);
`endif
            if (w >= 0) e_arready[w] = 1'b1;
        end else if (mo_addr_ph) begin
            e_arvalid = 1'b1;
            e_addr    = mo_addr;
            e_len     = mo_len[LW-1:0];
            e_id      = mo_owner[IW-1:0];
        end else begin
            e_rvalid[mo_owner] = m_rvalid;
            e_rdata  = m_rdata;
            e_rlast  = m_rlast;
            e_rready = req_rready[mo_owner];
        end
        chk("req_arready", req_arready, e_arready);
        chk("m_arvalid", m_arvalid, e_arvalid);
        chk("m_araddr", m_araddr, e_addr);
        chk("m_arlen", m_arlen, e_len);
        chk("m_arid", m_arid, e_id);
        chk("req_rvalid", req_rvalid, e_rvalid);
        chk("req_rdata", req_rdata, e_rdata);
        chk("req_rlast", req_rlast, e_rlast);
        chk("m_rready", m_rready, e_rready);
        chk("protocol_err", protocol_err, mo_err);
        if (!rst) begin
            if (mo_owner < 0) begin
                if (w >= 0) begin
                    mo_owner   = w;
                    mo_addr_ph = 1'b1;
                    mo_addr    = req_araddr[w*AW +: AW];
                    mo_len     = int'(req_arlen[w*LW +: LW]);
                end
            end else if (mo_addr_ph) begin
                if (m_arready) begin
                    mo_addr_ph = 1'b0;
                    mo_beats   = 0;
                end
            end else if (m_rvalid && req_rready[mo_owner]) begin
                if (m_rlast != (mo_beats == mo_len)) mo_err = 1'b1;
                if (int'(m_rid) != mo_owner) mo_err = 1'b1;
                mo_beats++;
                if (m_rlast) begin
`ifdef MEM_READ_ARB_RR_EN
                    mo_ptr = (mo_owner + 1) % N;
`endif
                    mo_owner = -1;
                end
            end
        end
    end

    int grant_log[$];
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_arready[i]) grant_log.push_back(i);
            end
        end
    end

    logic [N-1:0] acc;
    bit           hold_all = 1'b0;

    // Requesters drop arvalid on the edge that accepts them unless held on purpose.
    task automatic step();
        @(negedge clk);
        acc = req_arready;
        @(posedge clk);
        #1;
        if (!hold_all) req_arvalid = req_arvalid & ~acc;
    endtask

    task automatic serve(input int g, input int rid, input int nbeats, input int last_at,
                         input int ar_delay, input bit tog, output int got);
        int n;
        bit hs;
        bit ph;
        got = 0;
        ph  = 1'b0;
        n   = 0;
        while (m_arvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL ar_wait: m_arvalid absent after %0d cycles, want <20", n);
        end
        repeat (ar_delay) step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid = 1'b1;
            m_rid    = IW'(rid);
            m_rdata  = $urandom;
            m_rlast  = (b == last_at);
            n = 0;
            forever begin
                req_rready = tog ? {N{ph}} : '1;
                ph = ~ph;
                #1;
                hs = m_rready;
                if (hs && req_rvalid == N'(1 << g)) got++;
                step();
                if (hs) break;
                n++;
                if (n > 20) begin
                    total++; bad++;
                    $display("FAIL beat_wait: beat %0d unaccepted after %0d cycles", b, n);
                    break;
                end
            end
        end
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        m_rid      = '0;
        req_rready = '1;
    endtask

    function automatic void set_req(input int i, input logic [AW-1:0] a, input int len);
        req_araddr[i*AW +: AW] = a;
        req_arlen[i*LW +: LW]  = LW'(len);
    endfunction

    int got;
    int exp_order[6];
    int g1, g2;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request from the I-stream buffer, four beats
        set_req(2, 32'h1000, 3);
        req_arvalid = 3'b100;
        #1;
        chk("t1_arready", req_arready, 3'b100);
        step();
        chk("t1_arvalid_latency", m_arvalid, 1'b1);
        chk("t1_arid", m_arid, 4'd2);
        chk("t1_araddr", m_araddr, 32'h1000);
        serve(2, 2, 4, 3, 0, 1'b0, got);
        chk("t1_beats_on_req2", got, 4);

        // All three held: six single-beat bursts
        set_req(0, 32'h100, 0);
        set_req(1, 32'h200, 0);
        set_req(2, 32'h300, 0);
        hold_all = 1'b1;
        req_arvalid = 3'b111;
        grant_log.delete();
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_READ_ARB_RR_EN
            exp_order[k] = k % 3;
`else
            exp_order[k] = 0;
`endif
            serve(exp_order[k], exp_order[k], 1, 0, 0, 1'b0, got);
        end
        req_arvalid = '0;
        hold_all = 1'b0;
        chk("t2_grant_count", grant_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("t2_grant_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
        end

        // Backpressure: AR held off five cycles, requester rready toggling
        set_req(1, 32'h5000, 2);
        req_arvalid = 3'b010;
        serve(1, 1, 3, 2, 5, 1'b1, got);
        chk("t5_beats_no_loss", got, 3);
        chk("t5_no_err", protocol_err, 1'b0);

        // Wrong rid for grant 0
        set_req(0, 32'h0, 1);
        req_arvalid = 3'b001;
        serve(0, 1, 2, 1, 0, 1'b0, got);
        chk("t3_rid_err", protocol_err, 1'b1);
        chk("t3_idle_after", m_arvalid, 1'b0);

        // Reset after two of four beats
        set_req(2, 32'h2000, 3);
        req_arvalid = 3'b100;
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rid     = 4'd2;
        step();
        step();
        #1 rst = 1'b1;
        #1;
        chk("t7_rvalid_zero", req_rvalid, 3'b000);
        chk("t7_rready_zero", m_rready, 1'b0);
        chk("t7_err_cleared", protocol_err, 1'b0);
        step();
        chk("t7_arvalid_zero", m_arvalid, 1'b0);
        chk("t7_rdata_zero", req_rdata, 32'h0);
        m_rvalid = 1'b0;
        m_rid    = '0;
        rst      = 1'b0;

        // Served normally after the abort
        set_req(1, 32'h3000, 1);
        req_arvalid = 3'b010;
        serve(1, 1, 2, 1, 0, 1'b0, got);
        chk("t8_beats", got, 2);
        chk("t8_no_err", protocol_err, 1'b0);

        // rlast one beat early on a four-beat burst
        set_req(0, 32'h6000, 3);
        req_arvalid = 3'b001;
        serve(0, 0, 3, 2, 0, 1'b0, got);
        chk("t6_early_rlast_err", protocol_err, 1'b1);

        // Simultaneous requests from 0 and 1
        set_req(0, 32'h7000, 0);
        set_req(1, 32'h8000, 0);
        req_arvalid = 3'b011;
        grant_log.delete();
`ifdef MEM_READ_ARB_RR_EN
        g1 = 1; g2 = 0;
`else
        g1 = 0; g2 = 1;
`endif
        serve(g1, g1, 1, 0, 0, 1'b0, got);
        serve(g2, g2, 1, 0, 0, 1'b0, got);
        chk("t4_grant_count", grant_log.size(), 2);
        chk("t4_first", (grant_log.size() > 0) ? grant_log[0] : -1, g1);
        chk("t4_second", (grant_log.size() > 1) ? grant_log[1] : -1, g2);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
